keypad_event_queue: RTL and testbench
=====================================

KEYPAD_EVENT_QUEUE -- requirements
Module: keypad_event_queue

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 9, meaning number of raw key inputs (legal range 1..15).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 240000, meaning the number of cycles a raw key must hold a new level before the debounced state changes.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 24000000, meaning the debounced hold time (1 s at 24 MHz) that produces a long-press event.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning event queue depth (power of 2, minimum 2).
REQ-005 The block SHALL have port clock_24MHz  input  1  system clock, all logic on rising edge.
REQ-006 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port KEY  input  NUM_KEYS  raw active-high keys, asynchronous to the clock.
REQ-008 The block SHALL have port hold_en  input  1  enables long-press event generation.
REQ-009 The block SHALL have port clear_ovf  input  1  single-cycle clear of the overflow flag.
REQ-010 The block SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-011 The block SHALL have port evt_valid  output  1  queue non-empty; head event present.
REQ-012 The block SHALL have port evt_code  output  4  head event key code (key index + 1, range 1..NUM_KEYS).
REQ-013 The block SHALL have port evt_hold  output  1  head event is a long-press (1) or a press (0).
REQ-014 The block SHALL have port fifo_count  output  clog2(FIFO_DEPTH)+1  number of queued events.
REQ-015 The block SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-016 The block SHALL have port key_state  output  NUM_KEYS  debounced key levels.

Function
REQ-017 Each KEY bit SHALL pass through a 2-flop synchroniser before debouncing.
REQ-018 Each key SHALL have its own debounce counter: it counts while the synchronised level differs from key_state[i], clears on any agreement, and key_state[i] takes the new level on the cycle the count reaches DEB_CYCLES.
REQ-019 A 0->1 transition of key_state[i] SHALL set pending_press[i]; 1->0 transitions SHALL produce no event.
REQ-020 Each cycle, the arbiter SHALL enqueue at most one event: a pending hold event first, otherwise the lowest-index pending_press bit, then clear that pending bit.
REQ-021 Press latency SHALL be exactly 2 cycles from the key_state rise to evt_valid=1 when the queue is empty and no other event is pending.
REQ-022 The hold timer SHALL run only while hold_en=1 and exactly one key_state bit is 1; it SHALL clear on any key_state change or when hold_en=0.
REQ-023 When the hold timer reaches HOLD_CYCLES, the block SHALL raise one hold event (evt_hold=1, code of the held key) and SHALL NOT repeat it until key_state changes.
REQ-024 The FIFO SHALL be first-word-fall-through: evt_code and evt_hold are valid whenever evt_valid=1 and stay stable until popped.
REQ-025 The FIFO SHALL pop on evt_valid and evt_ready in the same cycle; evt_ready while empty SHALL be ignored.
REQ-026 A push and a pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-027 On a push while full without a pop, the event SHALL be dropped, the FIFO contents kept, and overflow set to 1.
REQ-028 clear_ovf SHALL clear overflow; a drop in the same cycle SHALL win and leave overflow=1.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL saturate at FIFO_DEPTH.

Reset
REQ-030 While RESET=1, the block SHALL hold: evt_valid=0, evt_code=0, evt_hold=0, fifo_count=0, overflow=0, key_state=0, all pending bits, counters, timers and pointers 0.
REQ-031 A RESET assertion mid-debounce or mid-hold SHALL discard all partial counts and queued events; after release, the block SHALL re-qualify keys still held from key_state=0 and produce a new press event after DEB_CYCLES.

Verification
REQ-032 Debounce: (DEB_CYCLES=16) KEY[2] bounces 5 cycles high, 3 low, then holds high -> key_state[2] rises exactly 16 stable cycles after the final edge plus 2 sync cycles; then a single event, code=3, evt_hold=0.
REQ-033 Simultaneous presses: KEY[0], KEY[4], KEY[8] rise in the same cycle, evt_ready=0 -> queue order codes 1,5,9; fifo_count=3.
REQ-034 Overflow: (FIFO_DEPTH=4) six presses with evt_ready=0 -> fifo_count=4, overflow=1, head code = first press; clear_ovf pulse -> overflow=0.
REQ-035 Full push+pop: FIFO full, evt_ready=1 in the same cycle as a new press -> fifo_count stays 4, overflow stays 0, new code at the tail.
REQ-036 Long press: (HOLD_CYCLES=100, hold_en=1) KEY[1] held 300 cycles -> one press event (code 2, hold 0) then one hold event (code 2, hold 1); no further events; with a second key held too -> no hold event.
REQ-037 Reset mid-hold: RESET pulse at hold cycle 50 with KEY[1] still high -> queue empty, then one fresh press event code 2 after debounce.

Source files
------------

// File: rtl/keypad_event_queue.sv
// Debounced keypad front end: per-key synchroniser and debounce, press / long-press
// detection, and a first-word-fall-through event queue with a sticky overflow flag.
module keypad_event_queue #(
  parameter int unsigned NUM_KEYS    = 9,
  parameter int unsigned DEB_CYCLES  = 240000,
  parameter int unsigned HOLD_CYCLES = 24000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clock_24MHz,
  input  logic                          RESET,
  input  logic [NUM_KEYS-1:0]           KEY,
  input  logic                          hold_en,
  input  logic                          clear_ovf,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [3:0]                    evt_code,
  output logic                          evt_hold,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [NUM_KEYS-1:0]           key_state
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q, key_state_q, key_prev_q;
  logic [DW-1:0]       deb_cnt_q [NUM_KEYS];
  logic [HW-1:0]       hold_tmr_q;
  logic                hold_fired_q, hold_pend_q, hold_pend_d;
  logic [3:0]          hold_code_q, hold_code;
  logic [NUM_KEYS-1:0] press_pend_q, press_pend_d;
  logic [NUM_KEYS-1:0] rise;
  logic                changed, one_hot, hold_fire;
  logic                push, push_hold, found;
  logic [3:0]          push_code;

  logic [3:0]          mem_code_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_hold_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                pop, full, wr_en, drop;

  // Edges are taken against a delayed copy so a press reaches the queue two cycles after key_state rises.
  assign rise    = key_state_q & ~key_prev_q;
  assign changed = (key_state_q != key_prev_q);
  assign one_hot = (key_state_q != '0) && ((key_state_q & (key_state_q - 1'b1)) == '0);
  assign hold_fire = hold_en && !changed && one_hot && !hold_fired_q &&
                     (hold_tmr_q == HW'(HOLD_CYCLES - 1));

  always_comb begin
    hold_code = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      if (key_state_q[i]) hold_code = 4'(i + 1);
  end

  always_ff @(posedge clock_24MHz or posedge RESET) begin
    if (RESET) begin
      key_s1_q     <= '0;
      key_s2_q     <= '0;
      key_state_q  <= '0;
      key_prev_q   <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) deb_cnt_q[i] <= '0;
      hold_tmr_q   <= '0;
      hold_fired_q <= 1'b0;
      hold_code_q  <= '0;
    end else begin
      key_s1_q   <= KEY;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_state_q;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (key_s2_q[i] == key_state_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          deb_cnt_q[i]   <= '0;
          key_state_q[i] <= key_s2_q[i];
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
      if (changed) hold_fired_q <= 1'b0;
      if (!hold_en || changed || !one_hot) begin
        hold_tmr_q <= '0;
      end else if (hold_fire) begin
        hold_tmr_q   <= '0;
        hold_fired_q <= 1'b1;
        hold_code_q  <= hold_code;
      end else if (!hold_fired_q) begin
        hold_tmr_q <= hold_tmr_q + 1'b1;
      end
    end
  end

  // One event per cycle: a pending hold beats presses, presses go lowest index first.
  always_comb begin
    press_pend_d = press_pend_q | rise;
    hold_pend_d  = hold_pend_q | hold_fire;
    push         = 1'b0;
    push_code    = '0;
    push_hold    = 1'b0;
    found        = 1'b0;
    if (hold_pend_q) begin
      push        = 1'b1;
      push_code   = hold_code_q;
      push_hold   = 1'b1;
      hold_pend_d = hold_fire;
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (!found && press_pend_q[i]) begin
          found           = 1'b1;
          push            = 1'b1;
          push_code       = 4'(i + 1);
          press_pend_d[i] = rise[i];
        end
      end
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && pop) cnt_d = cnt_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clear_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clock_24MHz or posedge RESET) begin
    if (RESET) begin
      press_pend_q <= '0;
      hold_pend_q  <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_code_q[i] <= '0;
      mem_hold_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      press_pend_q <= press_pend_d;
      hold_pend_q  <= hold_pend_d;
      if (wr_en) begin
        mem_code_q[wr_ptr_q] <= push_code;
        mem_hold_q[wr_ptr_q] <= push_hold;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign evt_code   = evt_valid ? mem_code_q[rd_ptr_q] : '0;
  assign evt_hold   = evt_valid ? mem_hold_q[rd_ptr_q] : 1'b0;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign key_state  = key_state_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue with a scoreboard of expected queue events.
module tb_keypad_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] key = '0;
  logic       hold_en = 1'b0, clear_ovf = 1'b0, evt_ready = 1'b0;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_hold;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [8:0] key_state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       hold;
  } evt_t;
  evt_t exp_q[$];
  evt_t e;

  keypad_event_queue #(
    .NUM_KEYS   (9),
    .DEB_CYCLES (16),
    .HOLD_CYCLES(100),
    .FIFO_DEPTH (4)
  ) dut (
    .clock_24MHz(clk),
    .RESET      (rst),
    .KEY        (key),
    .hold_en    (hold_en),
    .clear_ovf  (clear_ovf),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_hold   (evt_hold),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .key_state  (key_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_evt(input logic [3:0] code, input logic hold);
    evt_t x;
    x.code = code;
    x.hold = hold;
    exp_q.push_back(x);
  endtask

  // Waits (bounded) for a head event, checks it against the scoreboard, then pops it.
  task automatic consume(input string tag);
    evt_t x;
    int   n = 0;
    while (!evt_valid && n < 200) begin
      tick(1);
      n++;
    end
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    if (evt_valid) begin
      if (exp_q.size() != 0) x = exp_q.pop_front();
      else x = '0;
      chk({tag, "_code"}, 32'(evt_code), 32'(x.code));
      chk({tag, "_hold"}, 32'(evt_hold), 32'(x.hold));
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_hold", 32'(evt_hold), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_keys", 32'(key_state), 32'd0);
    rst = 1'b0;
    tick(2);

    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("empty_ready_count", 32'(fifo_count), 32'd0);
    chk("empty_ready_valid", 32'(evt_valid), 32'd0);

    // Debounce through a bounce on KEY[2]
    key[2] = 1'b1; tick(5);
    key[2] = 1'b0; tick(3);
    chk("bounce_ks", 32'(key_state[2]), 32'd0);
    key[2] = 1'b1;
    tick(17);
    chk("deb_early", 32'(key_state[2]), 32'd0);
    tick(1);
    chk("deb_rise", 32'(key_state[2]), 32'd1);
    tick(1);
    chk("press_lat1", 32'(evt_valid), 32'd0);
    tick(1);
    chk("press_lat2", 32'(evt_valid), 32'd1);
    expect_evt(4'd3, 1'b0);
    consume("deb_evt");
    chk("deb_single", 32'(fifo_count), 32'd0);
    key = '0;
    tick(20);

    // Simultaneous presses
    key[0] = 1'b1; key[4] = 1'b1; key[8] = 1'b1;
    expect_evt(4'd1, 1'b0); expect_evt(4'd5, 1'b0); expect_evt(4'd9, 1'b0);
    tick(24);
    chk("simul_count", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 3; i++) consume("simul");
    key = '0;
    tick(20);

    // Overflow, clear, and drop winning over clear
    key[5:0] = '1;
    for (int i = 1; i <= 4; i++) expect_evt(4'(i), 1'b0);
    tick(28);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(evt_code), 32'd1);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);
    key[6] = 1'b1;
    tick(19);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    chk("drop_wins_ovf", 32'(overflow), 32'd1);
    chk("drop_count", 32'(fifo_count), 32'd4);
    clear_ovf = 1'b1; tick(1); clear_ovf = 1'b0;
    chk("ovf_clear2", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) consume("ovf");
    key = '0;
    tick(20);

    // Full FIFO with simultaneous push and pop
    key[3:0] = '1;
    for (int i = 1; i <= 4; i++) expect_evt(4'(i), 1'b0);
    tick(24);
    chk("full_count", 32'(fifo_count), 32'd4);
    key[8] = 1'b1;
    tick(19);
    e = exp_q.pop_front();
    chk("full_head", 32'(evt_code), 32'(e.code));
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    expect_evt(4'd9, 1'b0);
    chk("pushpop_count", 32'(fifo_count), 32'd4);
    chk("pushpop_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) consume("pushpop");
    chk("pushpop_drain", 32'(fifo_count), 32'd0);
    key = '0;
    tick(20);

    // Long press on KEY[1]
    hold_en = 1'b1;
    key[1] = 1'b1;
    expect_evt(4'd2, 1'b0);
    consume("lp_press");
    tick(50);
    chk("lp_no_early", 32'(evt_valid), 32'd0);
    tick(48);
    chk("lp_before", 32'(evt_valid), 32'd0);
    tick(1);
    chk("lp_at", 32'(evt_valid), 32'd1);
    expect_evt(4'd2, 1'b1);
    consume("lp_hold");
    tick(150);
    chk("lp_no_repeat", 32'(evt_valid), 32'd0);
    key[3] = 1'b1;
    expect_evt(4'd4, 1'b0);
    consume("lp_second");
    tick(250);
    chk("two_keys_no_hold", 32'(evt_valid), 32'd0);
    key = '0;
    tick(40);
    chk("release_no_evt", 32'(evt_valid), 32'd0);

    // Reset in the middle of a hold with a queued event
    key[1] = 1'b1;
    tick(68);
    chk("pre_rst_count", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_valid", 32'(evt_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_keys", 32'(key_state), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    tick(1);
    chk("post_rst_empty", 32'(evt_valid), 32'd0);
    expect_evt(4'd2, 1'b0);
    tick(16);
    chk("requal_early", 32'(key_state[1]), 32'd0);
    tick(1);
    chk("requal_rise", 32'(key_state[1]), 32'd1);
    consume("requal");
    hold_en = 1'b0;
    key = '0;
    tick(30);
    chk("final_empty", 32'(evt_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
